vpi_line_bank_ctrl: RTL
=======================

Name: vpi_line_bank_ctrl

Overview:
Parametrised successor to the two-bank VPI line ping-pong controller. It packs PIX_WIDTH pixels into DATA_WIDTH words, stores each video line in one of BANK_NUM line banks, and drains the banks through a request/ack/done handshake. For each line it supplies the DDR line address and word length. Line overflow is detected and counted. Sits between VPI capture (already in DDR clock domain) and the DDR write arbiter.

Parameters:
PIX_WIDTH, 16, bits per pixel.
DATA_WIDTH, 128, RAM/DDR word width; must be an integer multiple of PIX_WIDTH; PPW = DATA_WIDTH/PIX_WIDTH.
BANK_NUM, 4, number of line banks; power of two, ≥2.
LINE_WORDS, 256, words per bank.
ADDR_WIDTH, 27, DDR address width.

Ports:
i_clk  in  1  single clock
i_rst  in  1  reset, synchronous, active-high
i_vs  in  1  vertical sync; rising edge = frame start
i_de  in  1  line valid; falling edge = line end
i_data_en  in  1  pixel qualifier, used together with i_de
i_pix_data  in  PIX_WIDTH  pixel
i_frame_base  in  ADDR_WIDTH  DDR address of line 0, sampled at frame start
i_line_stride  in  ADDR_WIDTH  address increment per line
o_ddr_req  out  1  bank ready, level held until ack
o_ddr_addr  out  ADDR_WIDTH  DDR address of requested line
o_ddr_len  out  clog2(LINE_WORDS+1)  word count of requested line
i_ddr_ack  in  1  1-cycle pulse, request accepted
i_ram_rd_addr  in  clog2(LINE_WORDS)  word address within active bank
o_ram_rd_data  out  DATA_WIDTH  read data, 1-cycle latency
i_ddr_wr_done  in  1  1-cycle pulse, bank drained
o_overflow  out  1  1-cycle pulse, line dropped
o_drop_cnt  out  16  dropped lines, saturating
o_full_cnt  out  clog2(BANK_NUM+1)  banks currently full

Behaviour:
- Reset (i_rst=1 at clock edge): all outputs 0; write and read pointers 0; all banks empty; pack state cleared; FSM in IDLE; line_addr=0. Memory contents are not cleared.
- Edge detect: vs_d1 and de_d1 are registered. pos_vs = i_vs & ~vs_d1. neg_de = de_d1 & ~i_de. Both are evaluated in the same cycle the input changes.
- Pixel accept: i_de & i_data_en. The pixel is shifted into the pack register; pixel 0 lands in bits [PIX_WIDTH-1:0].
- When pack count = PPW-1, the full word is written to {wr_ptr, word_addr} and word_addr increments.
- Words beyond LINE_WORDS-1 are discarded; length saturates at LINE_WORDS.
- Line drop latch: on the first accepted pixel of a line, if bank wr_ptr is full, line_drop is set and all RAM writes for that line are suppressed.
- On neg_de:
  - If the pack count is non-zero, the partial word is zero-padded in the upper bits and written (unless dropped). len = word_addr + (pack count != 0).
  - len=0: no commit, no line count.
  - len>0 and not line_drop: bank[wr_ptr] is marked full with {len, line_addr}, and wr_ptr = (wr_ptr+1) mod BANK_NUM.
  - len>0 and line_drop: o_overflow pulses in the next cycle; o_drop_cnt increments, saturating at 0xFFFF.
  - line_addr += i_line_stride for every non-empty line, dropped or not.
  - Pack state and word_addr are cleared.
- pos_vs: line_addr = i_frame_base; pack state, word_addr and line_drop are cleared. A partial line in progress is discarded. Already-full banks keep draining.
- pos_vs has priority over neg_de in the same cycle.
- Read FSM:
  - IDLE: if bank[rd_ptr] is full, go to REQ. o_ddr_req, o_ddr_addr and o_ddr_len are registered, valid from the first REQ cycle.
  - REQ: o_ddr_req=1 with addr/len stable. On i_ddr_ack, go to BUSY; o_ddr_req=0 from the next cycle.
  - BUSY: the read port serves bank rd_ptr. On i_ddr_wr_done, bank[rd_ptr] is cleared, rd_ptr increments mod BANK_NUM, and the FSM returns to IDLE.
  - Minimum gap between back-to-back requests: 1 IDLE cycle.
  - i_ddr_ack outside REQ is ignored; i_ddr_wr_done outside BUSY is ignored.
- o_ram_rd_data is registered from {rd_ptr, i_ram_rd_addr}. It is defined only in BUSY, and holds its last value otherwise.
- o_full_cnt tracks full banks. A commit and a done in the same cycle leave it unchanged. It never exceeds BANK_NUM.
- Same-cycle write and read of the same bank cannot occur: the line-drop rule forbids it.

Test Plan:
- Defaults, base=0x100, stride=0x40. Frame start, 16 pixels 0x0001..0x0010 → o_ddr_req=1, o_ddr_addr=0x100, o_ddr_len=2. After ack, rd_addr 0 returns 0x0008_0007_..._0001 one cycle later. Done → o_full_cnt=0.
- 10-pixel line → len=2. Word 1 = pixels 9,10 in the low 32 bits, upper 96 bits zero.
- 5 lines, no ack → o_full_cnt=4; line 5 dropped, o_overflow one pulse, o_drop_cnt=1. Ack + done, then line 6 → accepted with o_ddr_addr=0x100+5*0x40=0x240.
- Commit and i_ddr_wr_done in the same cycle → o_full_cnt unchanged. Ack asserted in IDLE → no state change.
- 2100-pixel line → len=256; words 0..255 correct, rest discarded. pos_vs mid-line → partial line not committed, next line address = new i_frame_base.
- i_rst during BUSY → next cycle o_ddr_req=0, o_full_cnt=0, FSM IDLE. The following line goes to bank 0.

Source files
------------

// File: rtl/vpi_line_bank_ctrl.sv
// Packs VPI pixels into words, buffers one line per bank and hands full banks to the DDR writer.
// Line commit lands 1 cycle after the line ends and the request follows 1 cycle later; a line that finds its bank full is dropped.
module vpi_line_bank_ctrl #(
    parameter int PIX_WIDTH  = 16,
    parameter int DATA_WIDTH = 128,
    parameter int BANK_NUM   = 4,
    parameter int LINE_WORDS = 256,
    parameter int ADDR_WIDTH = 27
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_vs,
    input  logic                              i_de,
    input  logic                              i_data_en,
    input  logic [PIX_WIDTH-1:0]              i_pix_data,
    input  logic [ADDR_WIDTH-1:0]             i_frame_base,
    input  logic [ADDR_WIDTH-1:0]             i_line_stride,
    output logic                              o_ddr_req,
    output logic [ADDR_WIDTH-1:0]             o_ddr_addr,
    output logic [$clog2(LINE_WORDS+1)-1:0]   o_ddr_len,
    input  logic                              i_ddr_ack,
    input  logic [$clog2(LINE_WORDS)-1:0]     i_ram_rd_addr,
    output logic [DATA_WIDTH-1:0]             o_ram_rd_data,
    input  logic                              i_ddr_wr_done,
    output logic                              o_overflow,
    output logic [15:0]                       o_drop_cnt,
    output logic [$clog2(BANK_NUM+1)-1:0]     o_full_cnt
);

    localparam int PPW   = DATA_WIDTH / PIX_WIDTH;
    localparam int PC_W  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int LEN_W = $clog2(LINE_WORDS + 1);
    localparam int RA_W  = $clog2(LINE_WORDS);
    localparam int BP_W  = $clog2(BANK_NUM);
    localparam int FC_W  = $clog2(BANK_NUM + 1);
    localparam int MEM_D = 1 << (BP_W + RA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_BUSY
    } rd_state_t;

    logic                  vs_d1_q, vs_d1_d;
    logic                  de_d1_q, de_d1_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic [PC_W-1:0]       pack_cnt_q, pack_cnt_d;
    logic [LEN_W-1:0]      word_addr_q, word_addr_d;
    logic                  line_act_q, line_act_d;
    logic                  line_drop_q, line_drop_d;
    logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [BP_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [BP_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [BANK_NUM-1:0]   bank_full_q, bank_full_d;
    logic [LEN_W-1:0]      bank_len_q [BANK_NUM];
    logic [LEN_W-1:0]      bank_len_d [BANK_NUM];
    logic [ADDR_WIDTH-1:0] bank_addr_q [BANK_NUM];
    logic [ADDR_WIDTH-1:0] bank_addr_d [BANK_NUM];
    logic [FC_W-1:0]       full_cnt_q, full_cnt_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    rd_state_t             state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] ddr_addr_q, ddr_addr_d;
    logic [LEN_W-1:0]      ddr_len_q, ddr_len_d;
    logic [DATA_WIDTH-1:0] rd_dat_q;

    logic [DATA_WIDTH-1:0] mem [MEM_D];
    logic                  ram_we;
    logic [BP_W+RA_W-1:0]  ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdat;

    logic                  pos_vs, neg_de, pix_acc, first_pix, drop_now;
    logic                  word_full, has_part, room;
    logic [DATA_WIDTH-1:0] pack_ins;
    logic [LEN_W:0]        line_len_raw;
    logic [LEN_W-1:0]      line_len;
    logic                  commit, rd_done;

    assign pos_vs    = i_vs & ~vs_d1_q;
    assign neg_de    = de_d1_q & ~i_de;
    assign pix_acc   = i_de & i_data_en;
    assign first_pix = pix_acc & ~line_act_q;
    // The drop decision is taken once, on the line's first pixel, and latched for the rest of the line.
    assign drop_now  = line_drop_q | (first_pix & bank_full_q[wr_ptr_q]);
    assign word_full = (pack_cnt_q == PC_W'(PPW - 1));
    assign has_part  = (pack_cnt_q != '0);
    assign room      = (word_addr_q < LEN_W'(LINE_WORDS));

    always_comb begin
        pack_ins = pack_q;
        pack_ins[pack_cnt_q*PIX_WIDTH +: PIX_WIDTH] = i_pix_data;
    end

    always_comb begin
        line_len_raw = {1'b0, word_addr_q} + (LEN_W+1)'(has_part);
        if (line_len_raw > (LEN_W+1)'(LINE_WORDS)) begin
            line_len = LEN_W'(LINE_WORDS);
        end else begin
            line_len = line_len_raw[LEN_W-1:0];
        end
    end

    // Write side: pixel packing, line termination and bank commit.
    always_comb begin
        vs_d1_d     = i_vs;
        de_d1_d     = i_de;
        pack_d      = pack_q;
        pack_cnt_d  = pack_cnt_q;
        word_addr_d = word_addr_q;
        line_act_d  = line_act_q;
        line_drop_d = line_drop_q;
        line_addr_d = line_addr_q;
        wr_ptr_d    = wr_ptr_q;
        bank_len_d  = bank_len_q;
        bank_addr_d = bank_addr_q;
        ovf_d       = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        commit      = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = {wr_ptr_q, word_addr_q[RA_W-1:0]};
        ram_wdat    = pack_ins;

        if (pos_vs) begin
            line_addr_d = i_frame_base;
            pack_d      = '0;
            pack_cnt_d  = '0;
            word_addr_d = '0;
            line_act_d  = 1'b0;
            line_drop_d = 1'b0;
        end else if (neg_de) begin
            if (has_part && !line_drop_q && room) begin
                ram_we   = 1'b1;
                ram_wdat = pack_q;
            end
            if (line_len != '0) begin
                line_addr_d = line_addr_q + i_line_stride;
                if (line_drop_q) begin
                    ovf_d = 1'b1;
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end else begin
                    commit                = 1'b1;
                    bank_len_d[wr_ptr_q]  = line_len;
                    bank_addr_d[wr_ptr_q] = line_addr_q;
                    wr_ptr_d              = wr_ptr_q + BP_W'(1);
                end
            end
            pack_d      = '0;
            pack_cnt_d  = '0;
            word_addr_d = '0;
            line_act_d  = 1'b0;
            line_drop_d = 1'b0;
        end else if (pix_acc) begin
            line_act_d  = 1'b1;
            line_drop_d = drop_now;
            if (word_full) begin
                pack_d     = '0;
                pack_cnt_d = '0;
                if (room) begin
                    word_addr_d = word_addr_q + LEN_W'(1);
                    ram_we      = ~drop_now;
                end
            end else begin
                pack_d     = pack_ins;
                pack_cnt_d = pack_cnt_q + PC_W'(1);
            end
        end
    end

    // Read side: one bank at a time is offered to the DDR writer.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        ddr_addr_d = ddr_addr_q;
        ddr_len_d  = ddr_len_q;
        rd_ptr_d   = rd_ptr_q;
        rd_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bank_full_q[rd_ptr_q]) begin
                    state_d    = ST_REQ;
                    req_d      = 1'b1;
                    ddr_addr_d = bank_addr_q[rd_ptr_q];
                    ddr_len_d  = bank_len_q[rd_ptr_q];
                end
            end
            ST_REQ: begin
                if (i_ddr_ack) begin
                    state_d = ST_BUSY;
                    req_d   = 1'b0;
                end
            end
            ST_BUSY: begin
                if (i_ddr_wr_done) begin
                    rd_done  = 1'b1;
                    rd_ptr_d = rd_ptr_q + BP_W'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        bank_full_d = bank_full_q;
        if (rd_done) begin
            bank_full_d[rd_ptr_q] = 1'b0;
        end
        if (commit) begin
            bank_full_d[wr_ptr_q] = 1'b1;
        end
        case ({commit, rd_done})
            2'b10:   full_cnt_d = full_cnt_q + FC_W'(1);
            2'b01:   full_cnt_d = full_cnt_q - FC_W'(1);
            default: full_cnt_d = full_cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vs_d1_q     <= 1'b0;
            de_d1_q     <= 1'b0;
            pack_q      <= '0;
            pack_cnt_q  <= '0;
            word_addr_q <= '0;
            line_act_q  <= 1'b0;
            line_drop_q <= 1'b0;
            line_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            bank_full_q <= '0;
            for (int b = 0; b < BANK_NUM; b++) begin
                bank_len_q[b]  <= '0;
                bank_addr_q[b] <= '0;
            end
            full_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            ddr_addr_q  <= '0;
            ddr_len_q   <= '0;
        end else begin
            vs_d1_q     <= vs_d1_d;
            de_d1_q     <= de_d1_d;
            pack_q      <= pack_d;
            pack_cnt_q  <= pack_cnt_d;
            word_addr_q <= word_addr_d;
            line_act_q  <= line_act_d;
            line_drop_q <= line_drop_d;
            line_addr_q <= line_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            bank_full_q <= bank_full_d;
            bank_len_q  <= bank_len_d;
            bank_addr_q <= bank_addr_d;
            full_cnt_q  <= full_cnt_d;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
            state_q     <= state_d;
            req_q       <= req_d;
            ddr_addr_q  <= ddr_addr_d;
            ddr_len_q   <= ddr_len_d;
        end
    end

    // Line storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_dat_q <= '0;
        end else if (state_q == ST_BUSY) begin
            rd_dat_q <= mem[{rd_ptr_q, i_ram_rd_addr}];
        end
    end

    assign o_ddr_req     = req_q;
    assign o_ddr_addr    = ddr_addr_q;
    assign o_ddr_len     = ddr_len_q;
    assign o_ram_rd_data = rd_dat_q;
    assign o_overflow    = ovf_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_full_cnt    = full_cnt_q;

endmodule
